// File: rtl/data_mem_access_ctrl.sv
// Load/store initiator for a word-wide data memory; sub-word stores are read-modify-write.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned/illegal requests instead of aligning them down.
module data_mem_access_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              memRead,
   output logic              memWrite,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] writeData,
   input  logic [DATA_W-1:0] readData
);
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   localparam logic [1:0] LAST = 2'(RD_LATENCY - 1);

   state_t            state_q, state_d;
   logic              write_q, write_d;
   logic [1:0]        size_q, size_d;
   logic              sgn_q, sgn_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] sdata_q, sdata_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [1:0]        cnt_q, cnt_d;

   logic [7:0]        rbyte;
   logic [15:0]       rhalf;
   logic [DATA_W-1:0] load_ext, merged;

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign memRead   = (state_q == RD);
   assign memWrite  = (state_q == WR);
   assign address   = {addr_q[ADDR_W-1:2], 2'b00};
   assign writeData = wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   // Lane extraction / merge are little-endian; size 11 falls through as a full word.
   always_comb begin
      rbyte    = readData[{addr_q[1:0], 3'b000} +: 8];
      rhalf    = addr_q[1] ? readData[31:16] : readData[15:0];
      load_ext = readData;
      merged   = readData;
      case (size_q)
         2'b00: begin
            load_ext = {{24{sgn_q & rbyte[7]}}, rbyte};
            merged[{addr_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
         end
         2'b01: begin
            load_ext = {{16{sgn_q & rhalf[15]}}, rhalf};
            if (addr_q[1]) merged[31:16] = sdata_q[15:0];
            else           merged[15:0]  = sdata_q[15:0];
         end
         default: ;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic mis;
   assign mis = (req_size == 2'b11) ||
                (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`endif

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      addr_d  = addr_q;
      sdata_d = sdata_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (req_valid) begin
            write_d = req_write;
            size_d  = req_size;
            sgn_d   = req_signed;
            addr_d  = req_addr;
            sdata_d = req_wdata;
            wdata_d = req_wdata;
            rdata_d = '0;
            err_d   = 1'b0;
            cnt_d   = '0;
            if (!req_write)           state_d = RD;
            else if (req_size[1])     state_d = WR;
            else                      state_d = RD;
`ifdef MISALIGN_TRAP_EN
            if (mis) begin
               err_d   = 1'b1;
               state_d = RESP;
            end
`endif
         end
         RD: begin
            if (cnt_q == LAST) begin
               if (write_q) begin
                  wdata_d = merged;
                  state_d = WR;
               end else begin
                  rdata_d = load_ext;
                  state_d = RESP;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         WR:   state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         size_q  <= '0;
         sgn_q   <= 1'b0;
         addr_q  <= '0;
         sdata_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Scoreboard bench for data_mem_access_ctrl against a small behavioural word memory.
module tb_data_mem_access_ctrl;
   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        memRead, memWrite;
   logic [31:0] address, writeData, readData;

   data_mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .memRead(memRead),
      .memWrite(memWrite), .address(address), .writeData(writeData),
      .readData(readData)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [16];
   assign readData = memRead ? mem[address[5:2]] : 32'h0;

   int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
   logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;

   always @(posedge clk) begin
      if (memWrite) begin
         mem[address[5:2]] <= writeData;
         wr_cnt       = wr_cnt + 1;
         last_wr_addr = address;
         last_wr_data = writeData;
      end
      if (memRead) begin
         rd_cnt       = rd_cnt + 1;
         last_rd_addr = address;
      end
      if (memRead && memWrite) both_cnt = both_cnt + 1;
   end

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;
   exp_t sb[$];

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // exp_lat = 0 skips the latency check; latency counts edges starting with the accept edge.
   task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                         input int hold, input int exp_rd, input int exp_wr);
      int   lat, rd0, wr0;
      exp_t e, got;
      e.d = exp_d;
      e.e = exp_e;
      @(negedge clk);
      chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      sb.push_back(e);
      rd0 = rd_cnt; wr0 = wr_cnt;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = 1'b0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      if (exp_lat != 0) chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      got = sb.pop_front();
      chk({tag, ".rdata"}, rsp_rdata, got.d);
      chk({tag, ".err"}, 32'(rsp_err), 32'(got.e));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({tag, ".hold_rdata"}, rsp_rdata, got.d);
         chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
         chk({tag, ".hold_mem"}, 32'(memRead | memWrite), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, ".post_ready"}, 32'(req_ready), 32'd1);
      chk({tag, ".post_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, ".rd_cycles"}, 32'(rd_cnt - rd0), 32'(exp_rd));
      chk({tag, ".wr_cycles"}, 32'(wr_cnt - wr0), 32'(exp_wr));
   endtask

   initial begin
      int wr0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      #1;
      chk("rst.req_ready", 32'(req_ready), 32'd1);
      chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst.rsp_err",   32'(rsp_err),   32'd0);
      chk("rst.rsp_rdata", rsp_rdata,      32'd0);
      chk("rst.mem_ctl",   32'({memRead, memWrite}), 32'd0);
      chk("rst.address",   address,        32'd0);
      chk("rst.writeData", writeData,      32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      // word store then word load
      do_req("st_w0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h10, 32'h0, 1'b0, 2, 0, 0, 1);
      chk("st_w0.addr",  last_wr_addr, 32'h0);
      chk("st_w0.wdata", last_wr_data, 32'h10);
      do_req("ld_w0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h10, 1'b0, LAT + 1, 0, LAT, 0);

      // byte store RMW
      mem[1] = 32'h11223344;
      do_req("st_b5", 1'b1, 2'b00, 1'b0, 32'h5, 32'hAB, 32'h0, 1'b0, LAT + 2, 0, LAT, 1);
      chk("st_b5.addr",  last_wr_addr, 32'h4);
      chk("st_b5.wdata", last_wr_data, 32'h1122AB44);
      do_req("ld_w4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h1122AB44, 1'b0, LAT + 1, 0, LAT, 0);

      // half store RMW into upper lane
      do_req("st_h6", 1'b1, 2'b01, 1'b0, 32'h6, 32'h1234BEEF, 32'h0, 1'b0, LAT + 2, 0, LAT, 1);
      chk("st_h6.wdata", last_wr_data, 32'hBEEFAB44);

      // sign/zero extension
      mem[1] = 32'h8122F3F0;
      do_req("ld_sb4", 1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 32'hFFFFFFF0, 1'b0, LAT + 1, 0, LAT, 0);
      do_req("ld_ub4", 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'h000000F0, 1'b0, LAT + 1, 0, LAT, 0);
      do_req("ld_sh6", 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'hFFFF8122, 1'b0, LAT + 1, 0, LAT, 0);
      do_req("ld_uh4", 1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 32'h0000F3F0, 1'b0, LAT + 1, 0, LAT, 0);
      do_req("ld_sb7", 1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 32'hFFFFFF81, 1'b0, LAT + 1, 0, LAT, 0);
      do_req("ld_ub5", 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'h000000F3, 1'b0, LAT + 1, 0, LAT, 0);

      // response back-pressure
      do_req("ld_bp", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h8122F3F0, 1'b0, LAT + 1, 3, LAT, 0);

      // misaligned word load
`ifdef MISALIGN_TRAP_EN
      do_req("ld_mis", 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 0, 0, 0, 0);
      do_req("st_ill", 1'b1, 2'b11, 1'b0, 32'h0, 32'h55, 32'h0, 1'b1, 0, 0, 0, 0);
`else
      do_req("ld_mis", 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h10, 1'b0, LAT + 1, 0, LAT, 0);
      chk("ld_mis.addr", last_rd_addr, 32'h0);
      do_req("ld_ill", 1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 32'h8122F3F0, 1'b0, LAT + 1, 0, LAT, 0);
`endif

      // reset during the read phase of a byte-store RMW
      mem[2] = 32'hCAFEF00D;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h9; req_wdata = 32'h77;
      wr0 = wr_cnt;
      @(posedge clk);
      #2;
      req_valid = 1'b0;
      chk("rst_rmw.in_rd", 32'(memRead), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_rmw.memRead", 32'(memRead), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      chk("rst_rmw.req_ready", 32'(req_ready), 32'd1);
      chk("rst_rmw.wr_cycles", 32'(wr_cnt - wr0), 32'd0);
      chk("rst_rmw.mem", mem[2], 32'hCAFEF00D);

      chk("never_both", 32'(both_cnt), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
